// File: rtl/ascon_ctrl_fsm.sv
// Sequencing controller for the ASCON-128 AEAD encryption datapath.
// Runs one permutation round per clock and decodes datapath strobes from state and round index.
module ascon_ctrl_fsm #(
   parameter int NB_ROUNDS_A = 12,
   parameter int NB_ROUNDS_B = 6
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       block_valid_i,
   input  logic       block_last_i,
   output logic       block_ready_o,
   output logic [3:0] round_o,
   output logic       en_reg_state_o,
   output logic       init_state_o,
   output logic [1:0] ena_xor_up_o,
   output logic [1:0] ena_xor_down_o,
   output logic       en_cipher_o,
   output logic       en_tag_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_INIT    = 3'd1;
   localparam logic [2:0] S_WAIT_AD = 3'd2;
   localparam logic [2:0] S_AD      = 3'd3;
   localparam logic [2:0] S_WAIT_PT = 3'd4;
   localparam logic [2:0] S_PT      = 3'd5;
   localparam logic [2:0] S_FINAL   = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   // p^a runs rounds 0..LAST_ROUND, p^b runs the tail FIRST_ROUND_B..LAST_ROUND
   localparam logic [3:0] LAST_ROUND    = 4'(NB_ROUNDS_A - 1);
   localparam logic [3:0] FIRST_ROUND_B = 4'(NB_ROUNDS_A - NB_ROUNDS_B);

   logic [2:0] state;
   logic [2:0] state_next;
   logic [3:0] round;
   logic [3:0] round_next;
   logic       ad_last;
   logic       ad_last_next;
   logic       transfer;
   logic       in_rounds;
   logic       phase_end;

   assign block_ready_o = (state == S_WAIT_AD) || (state == S_WAIT_PT);
   assign transfer      = block_ready_o && block_valid_i;
   assign in_rounds     = (state == S_INIT) || (state == S_AD) ||
                          (state == S_PT)   || (state == S_FINAL);
   assign phase_end     = (round == LAST_ROUND);

   always_comb begin
      state_next   = state;
      round_next   = round;
      ad_last_next = ad_last;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               state_next = S_INIT;
               round_next = 4'd0;
            end
         end
         S_WAIT_AD: begin
            if (transfer) begin
               state_next   = S_AD;
               round_next   = FIRST_ROUND_B;
               ad_last_next = block_last_i;
            end
         end
         S_WAIT_PT: begin
            // The last plaintext block is absorbed by the finalization itself
            if (transfer) begin
               state_next = block_last_i ? S_FINAL : S_PT;
               round_next = block_last_i ? 4'd0 : FIRST_ROUND_B;
            end
         end
         S_INIT, S_AD, S_PT, S_FINAL: begin
            if (!phase_end) begin
               round_next = round + 4'd1;
            end else begin
               case (state)
                  S_INIT:  state_next = S_WAIT_AD;
                  S_AD:    state_next = ad_last ? S_WAIT_PT : S_WAIT_AD;
                  S_PT:    state_next = S_WAIT_PT;
                  default: state_next = S_DONE;
               endcase
            end
         end
         default: begin
            state_next = S_IDLE;
            round_next = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state   <= S_IDLE;
         round   <= 4'd0;
         ad_last <= 1'b0;
      end else begin
         state   <= state_next;
         round   <= round_next;
         ad_last <= ad_last_next;
      end
   end

   always_comb begin
      en_reg_state_o = in_rounds;
      round_o        = in_rounds ? round : 4'd0;
      busy_o         = (state != S_IDLE);
      done_o         = (state == S_DONE);
      init_state_o   = 1'b0;
      ena_xor_up_o   = 2'b00;
      ena_xor_down_o = 2'b00;
      en_cipher_o    = 1'b0;
      en_tag_o       = 1'b0;
      case (state)
         S_INIT: begin
            init_state_o = (round == 4'd0);
            if (phase_end) ena_xor_down_o = 2'b01;
         end
         S_AD: begin
            if (round == FIRST_ROUND_B) ena_xor_up_o = 2'b01;
            if (phase_end && ad_last) ena_xor_down_o = 2'b10;
         end
         S_PT: begin
            if (round == FIRST_ROUND_B) begin
               ena_xor_up_o = 2'b01;
               en_cipher_o  = 1'b1;
            end
         end
         S_FINAL: begin
            if (round == 4'd0) begin
               ena_xor_up_o = 2'b11;
               en_cipher_o  = 1'b1;
            end
            if (phase_end) begin
               ena_xor_down_o = 2'b01;
               en_tag_o       = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Testbench for ascon_ctrl_fsm: per-cycle expected outputs are queued from the message
// structure as stimulus is built, then popped and compared cycle by cycle.
module tb_ascon_ctrl_fsm;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       block_valid;
   logic       block_last;
   logic       block_ready;
   logic [3:0] round;
   logic       en_reg_state;
   logic       init_state;
   logic [1:0] ena_xor_up;
   logic [1:0] ena_xor_down;
   logic       en_cipher;
   logic       en_tag;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   // Packed view: {busy,done,ready,en_reg,init,xup[1:0],xdown[1:0],cipher,tag,round[3:0]}
   logic [14:0] exp_q[$];
   logic [3:0]  stim_q[$];

   ascon_ctrl_fsm #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(6)) dut (
      .clock_i        (clock),
      .reset_i        (reset),
      .start_i        (start),
      .block_valid_i  (block_valid),
      .block_last_i   (block_last),
      .block_ready_o  (block_ready),
      .round_o        (round),
      .en_reg_state_o (en_reg_state),
      .init_state_o   (init_state),
      .ena_xor_up_o   (ena_xor_up),
      .ena_xor_down_o (ena_xor_down),
      .en_cipher_o    (en_cipher),
      .en_tag_o       (en_tag),
      .busy_o         (busy),
      .done_o         (done)
   );

   always #5 clock = ~clock;

   function automatic logic [14:0] mk(input logic b, input logic d, input logic rdy,
                                      input logic en, input logic ini,
                                      input logic [1:0] xu, input logic [1:0] xd,
                                      input logic ci, input logic tg, input logic [3:0] r);
      return {b, d, rdy, en, ini, xu, xd, ci, tg, r};
   endfunction

   function automatic void push(input logic [3:0] s, input logic [14:0] e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endfunction

   // Stimulus bits are {reset,start,valid,last}; valid stays high except during stalls
   function automatic void push_message(input int n_ad, input int n_pt, input int stall,
                                        input bit pulses, input int abort_round);
      logic [14:0] wait_out;
      wait_out = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0);
      push(4'b0110, 15'd0);
      for (int r = 0; r < 12; r++)
         push({1'b0, pulses && (r == 5), 1'b1, 1'b0},
              mk(1'b1, 1'b0, 1'b0, 1'b1, r == 0, 2'b00, (r == 11) ? 2'b01 : 2'b00,
                 1'b0, 1'b0, 4'(r)));
      for (int a = 0; a < n_ad; a++) begin
         push({3'b001, a == n_ad - 1}, wait_out);
         for (int r = 6; r < 12; r++) begin
            if (a == 0 && r == abort_round) begin
               push(4'b1010, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'(r)));
               push(4'b0000, 15'd0);
               return;
            end
            push(4'b0010, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (r == 6) ? 2'b01 : 2'b00,
                             (r == 11 && a == n_ad - 1) ? 2'b10 : 2'b00, 1'b0, 1'b0, 4'(r)));
         end
      end
      for (int p = 0; p < n_pt; p++) begin
         if (p == 0)
            for (int k = 0; k < stall; k++) push(4'b0000, wait_out);
         push({3'b001, p == n_pt - 1}, wait_out);
         if (p < n_pt - 1)
            for (int r = 6; r < 12; r++)
               push(4'b0010, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (r == 6) ? 2'b01 : 2'b00,
                                2'b00, r == 6, 1'b0, 4'(r)));
      end
      for (int r = 0; r < 12; r++)
         push({1'b0, pulses && (r == 3), 1'b1, 1'b0},
              mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (r == 0) ? 2'b11 : 2'b00,
                 (r == 11) ? 2'b01 : 2'b00, r == 0, r == 11, 4'(r)));
      push(4'b0010, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
      push(4'b0000, 15'd0);
   endfunction

   task automatic step(output logic [14:0] e, output logic [14:0] a);
      logic [3:0] s;
      @(negedge clock);
      a = {busy, done, block_ready, en_reg_state, init_state, ena_xor_up, ena_xor_down,
           en_cipher, en_tag, round};
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      {reset, start, block_valid, block_last} = s;
   endtask

   task automatic test_reset();
      logic [14:0] e, a;
      int i = 0;
      reset = 1'b1; start = 1'b0; block_valid = 1'b0; block_last = 1'b0;
      repeat (2) @(negedge clock);
      a = {busy, done, block_ready, en_reg_state, init_state, ena_xor_up, ena_xor_down,
           en_cipher, en_tag, round};
      n_checks++;
      if (a !== 15'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got %h, required %h", a, 15'd0);
      end
      reset = 1'b0;
      for (int k = 0; k < 5; k++) push(4'b0000, 15'd0);
      while (exp_q.size() > 0) begin
         step(e, a);
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("[TB] FAIL idle cycle %0d: got %h, required %h", i, a, e);
         end
         i++;
      end
   endtask

   task automatic test_single();
      logic [14:0] e, a;
      int i = 0, done_cnt = 0, done_at = -1, tag_cnt = 0;
      push_message(1, 1, 0, 1'b0, -1);
      while (exp_q.size() > 0) begin
         step(e, a);
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("[TB] FAIL single cycle %0d: got %h, required %h", i, a, e);
         end
         if (a[13]) begin done_cnt++; done_at = i; end
         if (a[4]) tag_cnt++;
         i++;
      end
      n_checks++;
      if (done_cnt !== 1 || done_at !== 33) begin
         n_fail++;
         $display("[TB] FAIL single_done: got %0d pulses at cycle %0d, required 1 at 33", done_cnt, done_at);
      end
      n_checks++;
      if (tag_cnt !== 1) begin
         n_fail++;
         $display("[TB] FAIL single_tag_count: got %0d, required 1", tag_cnt);
      end
   endtask

   task automatic test_multi_block();
      logic [14:0] e, a;
      int i = 0, done_at = -1, cipher_cnt = 0, ad_cnt = 0;
      push_message(2, 3, 0, 1'b0, -1);
      while (exp_q.size() > 0) begin
         step(e, a);
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("[TB] FAIL multi cycle %0d: got %h, required %h", i, a, e);
         end
         if (a[13]) done_at = i;
         if (a[5]) cipher_cnt++;
         if (a[9:8] == 2'b01 && !a[5]) ad_cnt++;
         i++;
      end
      n_checks++;
      if (done_at !== 54) begin
         n_fail++;
         $display("[TB] FAIL multi_done: got cycle %0d, required 54", done_at);
      end
      n_checks++;
      if (cipher_cnt !== 3 || ad_cnt !== 2) begin
         n_fail++;
         $display("[TB] FAIL multi_counts: got cipher %0d ad %0d, required cipher 3 ad 2", cipher_cnt, ad_cnt);
      end
   endtask

   task automatic test_stall();
      logic [14:0] e, a;
      int i = 0, done_at = -1;
      push_message(1, 1, 4, 1'b0, -1);
      while (exp_q.size() > 0) begin
         step(e, a);
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("[TB] FAIL stall cycle %0d: got %h, required %h", i, a, e);
         end
         if (a[13]) done_at = i;
         i++;
      end
      n_checks++;
      if (done_at !== 37) begin
         n_fail++;
         $display("[TB] FAIL stall_done: got cycle %0d, required 37", done_at);
      end
   endtask

   task automatic test_reset_abort();
      logic [14:0] e, a;
      int i = 0, done_at = -1;
      // Aborted run spans 18 entries, so the fresh start lands at entry 18
      push_message(1, 1, 0, 1'b0, 8);
      push_message(1, 1, 0, 1'b0, -1);
      while (exp_q.size() > 0) begin
         step(e, a);
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("[TB] FAIL abort cycle %0d: got %h, required %h", i, a, e);
         end
         if (a[13]) done_at = i;
         i++;
      end
      n_checks++;
      if (done_at !== 18 + 33) begin
         n_fail++;
         $display("[TB] FAIL abort_done: got cycle %0d, required %0d", done_at, 18 + 33);
      end
   endtask

   task automatic test_start_ignored();
      logic [14:0] e, a;
      int i = 0, done_cnt = 0;
      push_message(1, 1, 0, 1'b1, -1);
      for (int k = 0; k < 5; k++) push(4'b0000, 15'd0);
      while (exp_q.size() > 0) begin
         step(e, a);
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("[TB] FAIL start_ignored cycle %0d: got %h, required %h", i, a, e);
         end
         if (a[13]) done_cnt++;
         i++;
      end
      n_checks++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("[TB] FAIL start_ignored_done_count: got %0d, required 1", done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi_block();
      test_stall();
      test_reset_abort();
      test_start_ignored();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ascon_ctrl_fsm.md
# ascon_ctrl_fsm

Sequencing controller for the ASCON-128 AEAD encryption datapath: drives the permutation round index, the state-register enable, the upstream/downstream XOR enables and the ciphertext/tag capture strobes. It sits beside the permutation datapath, which holds the state register, round logic and `xor_up`/`xor_down` stages. It accepts 64-bit AD and plaintext blocks through a valid/ready handshake and signals completion after finalization. One round is executed per clock.

## Interface
- `NB_ROUNDS_A`, 12, rounds of p^a (initialization, finalization); round indices 0..11
- `NB_ROUNDS_B`, 6, rounds of p^b (AD, plaintext); round indices 12-NB_ROUNDS_B..11, i.e. 6..11
- `clock_i` in 1: single clock, rising edge
- `reset_i` in 1: reset, synchronous, active-high
- `start_i` in 1: begin a new encryption; sampled only in IDLE
- `block_valid_i` in 1: an AD/PT block is presented on the datapath data bus
- `block_last_i` in 1: the presented block is the last of its phase (AD or PT)
- `block_ready_o` out 1: controller is waiting for a block; transfer occurs when valid & ready
- `round_o` out 4: round-constant index for the current permutation round
- `en_reg_state_o` out 1: load the state register this cycle
- `init_state_o` out 1: permutation input mux selects IV||K||N instead of the state register
- `ena_xor_up_o` out 2: 00 none, 01 XOR data into state[0], 11 XOR data into state[0] and key into state[1..2]
- `ena_xor_down_o` out 2: 00 none, 01 XOR 0^*||K on permutation output, 10 XOR domain-separation bit (LSB of state[4])
- `en_cipher_o` out 1: capture ciphertext block (state[0] ^ data)
- `en_tag_o` out 1: capture tag from the permutation output
- `busy_o` out 1: high in every state except IDLE
- `done_o` out 1: one-cycle pulse at end of encryption

## Operation
- All outputs except `block_ready_o` are decoded from state and round counter (Moore). `block_ready_o` is 1 only in WAIT_AD and WAIT_PT.
- Round counter is 4-bit. It is loaded to 0 entering INIT/FINAL and to 12-NB_ROUNDS_B entering AD/PT. It increments while `en_reg_state_o`=1. The phase ends when the counter equals 11, and the counter never exceeds 11.
- States:
  - IDLE: all outputs 0. `start_i`=1 → INIT.
  - INIT: `en_reg_state_o`=1. `init_state_o`=1 on round 0 only. `ena_xor_down_o`=01 on round 11. After round 11 → WAIT_AD.
  - WAIT_AD: on transfer → AD, with the last flag latched.
  - AD: `en_reg_state_o`=1; `ena_xor_up_o`=01 on the first round. On round 11, if the latched last flag is set then `ena_xor_down_o`=10 and next state is WAIT_PT; otherwise next state is WAIT_AD.
  - WAIT_PT: transfer with last=0 → PT; transfer with last=1 → FINAL.
  - PT: `en_reg_state_o`=1; `ena_xor_up_o`=01 and `en_cipher_o`=1 on the first round. After round 11 → WAIT_PT.
  - FINAL: `en_reg_state_o`=1. `ena_xor_up_o`=11 and `en_cipher_o`=1 on round 0. `ena_xor_down_o`=01 and `en_tag_o`=1 on round 11. After round 11 → DONE.
  - DONE: `done_o`=1 for one cycle → IDLE.
- At least one AD block and one PT block per message. Empty phases are unsupported, and callers pad them to one block.

## Timing
- Reset: synchronous. `reset_i`=1 at any edge forces IDLE and counter 0, and aborts any operation in progress. All outputs are 0 in the cycle after reset, and no strobe is emitted.
- `start_i` while `busy_o`=1 is ignored. `block_valid_i` outside the WAIT states is ignored.
- A block is consumed in the cycle after its transfer edge. There is no bubble between a transfer and the first round.
- With `block_valid_i` held high, 1 AD block and 1 PT block, and `start_i` sampled at edge 0:
  - INIT occupies cycles 1-12.
  - WAIT_AD is cycle 13.
  - AD occupies cycles 14-19.
  - WAIT_PT is cycle 20.
  - FINAL occupies cycles 21-32.
  - DONE is cycle 33.
- Each additional AD or PT block adds 7 cycles: 1 wait + 6 rounds.
- `block_valid_i` low in a WAIT state: the controller stalls indefinitely, with all strobes 0 and `busy_o`=1.

## Test plan
- Reset, then idle with `start_i`=0 for 5 cycles → all outputs 0 and `busy_o`=0.
- Start with 1 AD and 1 PT block, valid always high → `done_o` pulses in cycle 33. `round_o` sequence is 0..11, then 6..11, then 0..11. `ena_xor_down_o`=01 in cycles 12 and 32, and 10 in cycle 19. `en_tag_o`=1 in cycle 32 only.
- Send 2 AD blocks and 3 PT blocks → 2 AD-phase transfers, and `en_cipher_o` pulses exactly 3 times (2 in PT, 1 at FINAL round 0). `done_o` in cycle 54.
- Hold `block_valid_i` low for 4 cycles in WAIT_PT → `block_ready_o` stays 1, no rounds run, `round_o` is stable, and the sequence resumes unchanged afterwards.
- Assert `reset_i` during AD round 8 → IDLE next cycle with all outputs 0. A fresh start then gives `done_o` 33 cycles later.
- Pulse `start_i` during INIT and again during FINAL → ignored. Exactly one `done_o` is produced.
